// File: rtl/conv_pkg.sv
// Shared definitions for the narrow-to-wide gearbox: mode encodings,
// default widths and the beats-per-word helpers.
package conv_pkg;

  localparam int IN_W_DEF  = 8;
  localparam int OUT_W_DEF = 32;

  localparam logic [1:0] MODE_1B = 2'd0;
  localparam logic [1:0] MODE_2B = 2'd1;
  localparam logic [1:0] MODE_4B = 2'd2;
  localparam logic [1:0] MODE_8B = 2'd3;

  // Requested beats per word (1<<mode), clamped to what the output word holds.
  function automatic int unsigned beats_for_mode(input logic [1:0] mode,
                                                 input int unsigned ratio);
    int unsigned req;
    req = 32'd1 << mode;
    return (req > ratio) ? ratio : req;
  endfunction

  function automatic logic mode_exceeds(input logic [1:0] mode,
                                        input int unsigned ratio);
    return (32'd1 << mode) > ratio;
  endfunction

endpackage

// File: rtl/conv_lane_pack.sv
// Places one input beat into its lane of an otherwise-zero output word.
// CONV_BYTE_SWAP_EN selects MSB-first lane order instead of little-endian.
module conv_lane_pack
  import conv_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  localparam int RATIO = OUT_W / IN_W,
  localparam int CW    = $clog2(RATIO) + 1
) (
  input  logic [IN_W-1:0]  beat_i,
  input  logic [CW-1:0]    lane_i,
  output logic [OUT_W-1:0] word_o
);

  // NOTE: word_o gets a full default before the loop so no path leaves it
  // unassigned; without it this block would infer a latch.
  always_comb begin
    word_o = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (lane_i == CW'(k)) begin
`ifdef CONV_BYTE_SWAP_EN
        word_o[(RATIO-1-k)*IN_W +: IN_W] = beat_i;
`else
        word_o[k*IN_W +: IN_W] = beat_i;
`endif
      end
    end
  end

endmodule

// File: rtl/conv_gearbox_nm.sv
// Narrow-to-wide gearbox: packs IN_W beats into OUT_W words with valid/ready
// on both sides, run-time beats-per-word mode and flush. See CONV_BYTE_SWAP_EN.
module conv_gearbox_nm
  import conv_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  localparam int RATIO = OUT_W / IN_W,
  localparam int CW    = $clog2(RATIO) + 1
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic [1:0]       MODE,
  input  logic [IN_W-1:0]  IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             FLUSH,
  output logic [OUT_W-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [CW-1:0]    BEAT_CNT,
  output logic [OUT_W-1:0] PART,
  output logic             MODE_ERR
);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    beats_q, beats_d;
  logic [OUT_W-1:0] part_q, part_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             mode_err_q, mode_err_d;

  logic             out_free;
  logic             accept;
  logic             word_start;
  logic [CW-1:0]    mode_beats;
  logic [CW-1:0]    word_beats;
  logic             last_beat;
  logic [OUT_W-1:0] lane_word;
  logic [OUT_W-1:0] merged;

  // The output register is free when empty or being read this same cycle.
  assign out_free   = !out_valid_q || OUT_READY;
  assign IN_READY   = ENB && out_free;
  assign accept     = IN_VALID && IN_READY;
  assign word_start = accept && (cnt_q == '0);

  assign mode_beats = CW'(beats_for_mode(MODE, RATIO));
  assign word_beats = word_start ? mode_beats : beats_q;
  assign last_beat  = (cnt_q == word_beats - 1'b1);

  conv_lane_pack #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_lane_pack (
    .beat_i (IN_DATA),
    .lane_i (cnt_q),
    .word_o (lane_word)
  );

  assign merged = part_q | lane_word;

  always_comb begin
    cnt_d       = cnt_q;
    beats_d     = beats_q;
    part_d      = part_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    mode_err_d  = 1'b0;

    if (ENB) begin
      if (out_valid_q && OUT_READY) begin
        out_valid_d = 1'b0;
      end

      if (word_start) begin
        beats_d    = mode_beats;
        mode_err_d = mode_exceeds(MODE, RATIO);
      end

      if (accept) begin
        if (last_beat || FLUSH) begin
          out_data_d  = merged;
          out_valid_d = 1'b1;
          part_d      = '0;
          cnt_d       = '0;
        end else begin
          part_d = merged;
          cnt_d  = cnt_q + 1'b1;
        end
      end else if (FLUSH && (cnt_q != '0) && out_free) begin
        // Lanes not yet written are already zero, so PART is the padded word.
        out_data_d  = part_q;
        out_valid_d = 1'b1;
        part_d      = '0;
        cnt_d       = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      cnt_q       <= '0;
      beats_q     <= CW'(RATIO);
      part_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      mode_err_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      beats_q     <= beats_d;
      part_q      <= part_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      mode_err_q  <= mode_err_d;
    end
  end

  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign BEAT_CNT  = cnt_q;
  assign PART      = part_q;
  assign MODE_ERR  = mode_err_q;

endmodule

// File: tb/tb_conv_gearbox_nm.sv
// Directed bench for conv_gearbox_nm: expected words queued at stimulus time,
// popped and compared whenever the DUT hands a word downstream.
module tb_conv_gearbox_nm;

  localparam int IN_W  = 8;
  localparam int OUT_W = 32;
  localparam int CW    = 3;

  logic             CLK = 1'b0;
  logic             RESET_L;
  logic             ENB;
  logic [1:0]       MODE;
  logic [IN_W-1:0]  IN_DATA;
  logic             IN_VALID;
  logic             IN_READY;
  logic             FLUSH;
  logic [OUT_W-1:0] OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [CW-1:0]    BEAT_CNT;
  logic [OUT_W-1:0] PART;
  logic             MODE_ERR;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 CLK = ~CLK;

  conv_gearbox_nm #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .ENB       (ENB),
    .MODE      (MODE),
    .IN_DATA   (IN_DATA),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .FLUSH     (FLUSH),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .BEAT_CNT  (BEAT_CNT),
    .PART      (PART),
    .MODE_ERR  (MODE_ERR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    IN_VALID = 1'b1;
    IN_DATA  = b;
    @(negedge CLK);
    check("in_ready_on_send", 32'(IN_READY), 32'd1);
    tick();
    IN_VALID = 1'b0;
  endtask

  // Scoreboard: a word is consumed on an edge where OUT_VALID and OUT_READY are both high.
  always @(negedge CLK) begin
    if (RESET_L === 1'b1 && ENB === 1'b1 && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", OUT_DATA, 32'hxxxx_xxxx);
      end else begin
        check("word", OUT_DATA, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    RESET_L   = 1'b0;
    ENB       = 1'b1;
    MODE      = 2'd2;
    IN_DATA   = '0;
    IN_VALID  = 1'b0;
    FLUSH     = 1'b0;
    OUT_READY = 1'b1;
    #2;
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_out_data",  OUT_DATA, 32'd0);
    check("rst_beat_cnt",  32'(BEAT_CNT), 32'd0);
    check("rst_part",      PART, 32'd0);
    check("rst_mode_err",  32'(MODE_ERR), 32'd0);
    tick();
    RESET_L = 1'b1;
    tick();

    // Four-beat word, read immediately.
`ifdef CONV_BYTE_SWAP_EN
    exp_q.push_back(32'h11223344);
`else
    exp_q.push_back(32'h44332211);
`endif
    send(8'h11);
    send(8'h22);
`ifdef CONV_BYTE_SWAP_EN
    check("part_2beats", PART, 32'h11220000);
`else
    check("part_2beats", PART, 32'h00002211);
`endif
    check("cnt_2beats", 32'(BEAT_CNT), 32'd2);
    send(8'h33);
    check("no_early_valid", 32'(OUT_VALID), 32'd0);
    send(8'h44);
    check("latency_valid", 32'(OUT_VALID), 32'd1);
    check("cnt_after_word", 32'(BEAT_CNT), 32'd0);
    check("part_after_word", PART, 32'd0);
    tick();
    check("valid_one_cycle", 32'(OUT_VALID), 32'd0);

    // Two-beat mode, back-to-back words.
    MODE = 2'd1;
`ifdef CONV_BYTE_SWAP_EN
    exp_q.push_back(32'hAABB0000);
    exp_q.push_back(32'hCCDD0000);
`else
    exp_q.push_back(32'h0000BBAA);
    exp_q.push_back(32'h0000DDCC);
`endif
    send(8'hAA); check("cnt_seq0", 32'(BEAT_CNT), 32'd1);
    send(8'hBB); check("cnt_seq1", 32'(BEAT_CNT), 32'd0);
    send(8'hCC); check("cnt_seq2", 32'(BEAT_CNT), 32'd1);
    send(8'hDD); check("cnt_seq3", 32'(BEAT_CNT), 32'd0);
    tick();

    // Partial word, ENB-low freeze, then flush.
    MODE = 2'd2;
`ifdef CONV_BYTE_SWAP_EN
    exp_q.push_back(32'h01020000);
`else
    exp_q.push_back(32'h00000201);
`endif
    send(8'h01);
    ENB = 1'b0;
    IN_VALID = 1'b1;
    IN_DATA  = 8'hEE;
    @(negedge CLK);
    check("enb_low_in_ready", 32'(IN_READY), 32'd0);
    tick();
    IN_VALID = 1'b0;
    check("enb_low_cnt_hold", 32'(BEAT_CNT), 32'd1);
    ENB = 1'b1;
    send(8'h02);
    FLUSH = 1'b1;
    tick();
    check("flush_cnt", 32'(BEAT_CNT), 32'd0);
    check("flush_valid", 32'(OUT_VALID), 32'd1);
    tick();
    check("flush_empty_noop", 32'(OUT_VALID), 32'd0);
    FLUSH = 1'b0;
    tick();

    // Back-pressure holds the word and blocks input.
    OUT_READY = 1'b0;
`ifdef CONV_BYTE_SWAP_EN
    exp_q.push_back(32'hA1A2A3A4);
`else
    exp_q.push_back(32'hA4A3A2A1);
`endif
    send(8'hA1);
    send(8'hA2);
    send(8'hA3);
    send(8'hA4);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_in_ready", 32'(IN_READY), 32'd0);
      check("stall_valid", 32'(OUT_VALID), 32'd1);
`ifdef CONV_BYTE_SWAP_EN
      check("stall_data", OUT_DATA, 32'hA1A2A3A4);
`else
      check("stall_data", OUT_DATA, 32'hA4A3A2A1);
`endif
      tick();
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    check("release_in_ready", 32'(IN_READY), 32'd1);
    tick();
    check("release_valid_clear", 32'(OUT_VALID), 32'd0);

    // Oversized mode clamps; mid-word mode change deferred to next word.
    MODE = 2'd3;
`ifdef CONV_BYTE_SWAP_EN
    exp_q.push_back(32'h10203040);
    exp_q.push_back(32'h77000000);
`else
    exp_q.push_back(32'h40302010);
    exp_q.push_back(32'h00000077);
`endif
    send(8'h10);
    check("mode_err_pulse", 32'(MODE_ERR), 32'd1);
    send(8'h20);
    check("mode_err_single", 32'(MODE_ERR), 32'd0);
    MODE = 2'd0;
    send(8'h30);
    check("mode_change_ignored", 32'(OUT_VALID), 32'd0);
    send(8'h40);
    check("clamped_word_valid", 32'(OUT_VALID), 32'd1);
    send(8'h77);
    check("next_word_mode0", 32'(OUT_VALID), 32'd1);
    check("mode0_no_err", 32'(MODE_ERR), 32'd0);
    tick();

    // Asynchronous reset mid-word discards the partial data.
    MODE = 2'd2;
    send(8'h01);
    send(8'h02);
    #3;
    RESET_L = 1'b0;
    #1;
    check("async_rst_cnt", 32'(BEAT_CNT), 32'd0);
    check("async_rst_part", PART, 32'd0);
    check("async_rst_valid", 32'(OUT_VALID), 32'd0);
    check("async_rst_data", OUT_DATA, 32'd0);
    tick();
    RESET_L = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_no_word", 32'(OUT_VALID), 32'd0);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
